// File: rtl/seg_scan_reader.sv
// Reader side of a multiplexed 7-segment display bus: recovers per-digit BCD,
// decimal point and glyph-error flags from one full scan and offers it as a frame.
module seg_scan_reader #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an_in,
   input  logic [7:0]              seg_in,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic [4*NUM_DIGITS-1:0] frame_bcd,
   output logic [NUM_DIGITS-1:0]   frame_dp,
   output logic [NUM_DIGITS-1:0]   frame_err,
   output logic                    overrun
);

   typedef enum logic {COLLECT, HOLD} state_t;

   // Comparing the first synchronizer stage against the second lets the counter
   // see a change one edge earlier, so capture lands STABLE_CYCLES+1 edges after the pins settle.
   localparam logic [7:0] CAP_COUNT = 8'(STABLE_CYCLES - 2);

   logic [NUM_DIGITS-1:0]   an_s1, an_s2;
   logic [7:0]              seg_s1, seg_s2;
   logic [7:0]              stable_cnt;
   logic                    same, one_low, capture, frame_done;
   logic [NUM_DIGITS-1:0]   sel;
   logic [3:0]              dec_code;
   logic                    dec_err;
   logic [4*NUM_DIGITS-1:0] slot_bcd;
   logic [NUM_DIGITS-1:0]   slot_dp, slot_err, seen;
   state_t                  state, state_next;
   logic                    load, clear_seen, valid_next, overrun_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_s1  <= '0;
         an_s2  <= '0;
         seg_s1 <= '0;
         seg_s2 <= '0;
      end else begin
         an_s1  <= an_in;
         an_s2  <= an_s1;
         seg_s1 <= seg_in;
         seg_s2 <= seg_s1;
      end
   end

   assign same = (an_s1 == an_s2) && (seg_s1 == seg_s2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_cnt <= '0;
      end else if (!same) begin
         stable_cnt <= '0;
      end else if (stable_cnt != 8'hFF) begin
         stable_cnt <= stable_cnt + 8'd1;
      end
   end

   assign sel        = ~an_s2;
   assign one_low    = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
   assign capture    = same && (stable_cnt == CAP_COUNT) && one_low;
   assign frame_done = &seen;

   always_comb begin
      dec_code = 4'hE;
      dec_err  = 1'b1;
      case (seg_s2[6:0])
         7'h40: begin dec_code = 4'h0; dec_err = 1'b0; end
         7'h79: begin dec_code = 4'h1; dec_err = 1'b0; end
         7'h24: begin dec_code = 4'h2; dec_err = 1'b0; end
         7'h30: begin dec_code = 4'h3; dec_err = 1'b0; end
         7'h19: begin dec_code = 4'h4; dec_err = 1'b0; end
         7'h12: begin dec_code = 4'h5; dec_err = 1'b0; end
         7'h02: begin dec_code = 4'h6; dec_err = 1'b0; end
         7'h78: begin dec_code = 4'h7; dec_err = 1'b0; end
         7'h00: begin dec_code = 4'h8; dec_err = 1'b0; end
         7'h10: begin dec_code = 4'h9; dec_err = 1'b0; end
         7'h7F: begin dec_code = 4'hF; dec_err = 1'b0; end
         default: ;
      endcase
   end

   // A recapture of a digit inside the same frame simply overwrites its slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_bcd <= '0;
         slot_dp  <= '0;
         slot_err <= '0;
      end else if (capture) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel[k]) begin
               slot_bcd[4*k +: 4] <= dec_code;
               slot_dp[k]         <= ~seg_s2[7];
               slot_err[k]        <= dec_err;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= '0;
      end else begin
         seen <= (clear_seen ? '0 : seen) | (capture ? sel : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   // In HOLD a completed frame replaces the held one only if it is accepted on that edge.
   always_comb begin
      state_next   = state;
      load         = 1'b0;
      clear_seen   = 1'b0;
      valid_next   = frame_valid;
      overrun_next = 1'b0;
      case (state)
         COLLECT: begin
            if (frame_done) begin
               load       = 1'b1;
               clear_seen = 1'b1;
               valid_next = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (frame_ready) begin
               if (frame_done) begin
                  load       = 1'b1;
                  clear_seen = 1'b1;
               end else begin
                  valid_next = 1'b0;
                  state_next = COLLECT;
               end
            end else if (frame_done) begin
               overrun_next = 1'b1;
               clear_seen   = 1'b1;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
         frame_bcd   <= '0;
         frame_dp    <= '0;
         frame_err   <= '0;
      end else begin
         frame_valid <= valid_next;
         overrun     <= overrun_next;
         if (load) begin
            frame_bcd <= slot_bcd;
            frame_dp  <= slot_dp;
            frame_err <= slot_err;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Randomized self-checking bench for seg_scan_reader with a slot/frame reference model.
module tb_seg_scan_reader;
   localparam int ND = 4;
   localparam int SC = 4;
   localparam logic [ND-1:0] BLANK = '1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [ND-1:0]   an_in;
   logic [7:0]      seg_in;
   logic            frame_valid;
   logic            frame_ready;
   logic [4*ND-1:0] frame_bcd;
   logic [ND-1:0]   frame_dp;
   logic [ND-1:0]   frame_err;
   logic            overrun;

   int n_vec = 0;
   int n_bad = 0;

   logic [6:0]      glyph [10];
   logic [4*ND-1:0] m_bcd;
   logic [ND-1:0]   m_dp, m_err;

   seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n), .an_in(an_in), .seg_in(seg_in),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_bcd(frame_bcd), .frame_dp(frame_dp), .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [ND-1:0] dig(input int k);
      logic [ND-1:0] a;
      a    = '1;
      a[k] = 1'b0;
      return a;
   endfunction

   function automatic logic [7:0] rand_seg();
      int c;
      c = int'($urandom_range(0, 9));
      if (c <= 6) return {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 9)]};
      if (c == 7) return {1'($urandom_range(0, 1)), 7'h7F};
      return 8'($urandom);
   endfunction

   // Slot model: what digit k should report after pattern seg has been captured.
   task automatic model_capture(input int k, input logic [7:0] seg);
      logic [3:0] code;
      logic       err;
      code = 4'hE;
      err  = 1'b1;
      if (seg[6:0] == 7'h7F) begin
         code = 4'hF;
         err  = 1'b0;
      end
      for (int v = 0; v < 10; v++) begin
         if (seg[6:0] == glyph[v]) begin
            code = 4'(v);
            err  = 1'b0;
         end
      end
      m_bcd[4*k +: 4] = code;
      m_dp[k]         = ~seg[7];
      m_err[k]        = err;
   endtask

   task automatic set_pins(input logic [ND-1:0] an, input logic [7:0] seg);
      @(negedge clk);
      an_in  = an;
      seg_in = seg;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_pins(input logic [ND-1:0] an, input logic [7:0] seg, input int cycles);
      set_pins(an, seg);
      repeat (cycles) tick();
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      an_in       = BLANK;
      seg_in      = 8'hFF;
      frame_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", frame_valid); end
      n_vec++; if (frame_bcd !== '0) begin n_bad++; $display("[TB] FAIL reset_bcd: got %h want 0", frame_bcd); end
      n_vec++; if (frame_dp !== '0) begin n_bad++; $display("[TB] FAIL reset_dp: got %b want 0", frame_dp); end
      n_vec++; if (frame_err !== '0) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", frame_err); end
      n_vec++; if (overrun !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] segs [ND];
      logic       want;
      segs        = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
      frame_ready = 1'b1;
      hold_pins(BLANK, 8'hFF, 3);
      for (int k = 0; k < ND - 1; k++) begin
         hold_pins(dig(k), segs[k], 10);
         model_capture(k, segs[k]);
      end
      set_pins(dig(ND - 1), segs[ND - 1]);
      model_capture(ND - 1, segs[ND - 1]);
      for (int e = 1; e <= 10; e++) begin
         tick();
         want = (e == SC + 2);
         n_vec++;
         if (frame_valid !== want) begin
            n_bad++;
            $display("[TB] FAIL basic_valid_edge%0d: got %b want %b", e, frame_valid, want);
         end
      end
      n_vec++; if (frame_bcd !== 16'h3210) begin n_bad++; $display("[TB] FAIL basic_bcd: got %h want 3210", frame_bcd); end
      n_vec++; if (frame_dp !== 4'b0000) begin n_bad++; $display("[TB] FAIL basic_dp: got %b want 0000", frame_dp); end
      n_vec++; if (frame_err !== 4'b0000) begin n_bad++; $display("[TB] FAIL basic_err: got %b want 0000", frame_err); end
   endtask

   task automatic test_decode();
      logic [7:0] segs [ND];
      int         pulses;
      segs        = '{8'h80, 8'h10, 8'hFF, 8'h8C};
      frame_ready = 1'b1;
      pulses      = 0;
      hold_pins(BLANK, 8'hFF, 3);
      for (int k = 0; k < ND; k++) begin
         set_pins(dig(k), segs[k]);
         for (int e = 0; e < 10; e++) begin
            tick();
            if (frame_valid === 1'b1) pulses++;
         end
      end
      n_vec++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL decode_valid_pulses: got %0d want 1", pulses); end
      n_vec++; if (frame_bcd !== 16'hEF98) begin n_bad++; $display("[TB] FAIL decode_bcd: got %h want ef98", frame_bcd); end
      n_vec++; if (frame_dp !== 4'b0010) begin n_bad++; $display("[TB] FAIL decode_dp: got %b want 0010", frame_dp); end
      n_vec++; if (frame_err !== 4'b1000) begin n_bad++; $display("[TB] FAIL decode_err: got %b want 1000", frame_err); end
   endtask

   task automatic test_glitch();
      int pulses;
      frame_ready = 1'b1;
      hold_pins(BLANK, 8'hFF, 3);
      for (int k = 0; k < ND; k++) begin
         set_pins(dig(k), {1'b1, glyph[k]});
         repeat (3) begin
            tick();
            n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_short_valid: got %b want 0", frame_valid); end
         end
      end
      set_pins(4'b0011, 8'hC0);
      repeat (20) begin
         tick();
         n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_multi_valid: got %b want 0", frame_valid); end
      end
      set_pins(BLANK, 8'hC0);
      repeat (20) begin
         tick();
         n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_blank_valid: got %b want 0", frame_valid); end
      end
      set_pins(dig(ND - 1), 8'hB0);
      model_capture(ND - 1, 8'hB0);
      repeat (10) begin
         tick();
         n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_no_capture: got %b want 0", frame_valid); end
      end
      pulses = 0;
      for (int k = 0; k < ND - 1; k++) begin
         set_pins(dig(k), {1'b0, glyph[k + 5]});
         model_capture(k, {1'b0, glyph[k + 5]});
         repeat (10) begin
            tick();
            if (frame_valid === 1'b1) pulses++;
         end
      end
      n_vec++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL glitch_recover_pulses: got %0d want 1", pulses); end
      n_vec++; if (frame_bcd !== m_bcd || frame_dp !== m_dp || frame_err !== m_err) begin
         n_bad++;
         $display("[TB] FAIL glitch_frame: got %h/%b/%b want %h/%b/%b", frame_bcd, frame_dp, frame_err, m_bcd, m_dp, m_err);
      end
   endtask

   task automatic test_random();
      int         order [ND];
      int         seq [$];
      int         j, t;
      logic [7:0] s;
      frame_ready = 1'b0;
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < ND; i++) order[i] = i;
         for (int i = ND - 1; i > 0; i--) begin
            j        = int'($urandom_range(0, i));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
         end
         seq.delete();
         for (int i = 0; i < ND - 1; i++) seq.push_back(order[i]);
         seq.push_back(order[$urandom_range(0, ND - 2)]);
         seq.push_back(order[ND - 1]);
         hold_pins(BLANK, 8'hFF, 3);
         foreach (seq[i]) begin
            s = rand_seg();
            hold_pins(dig(seq[i]), s, int'($urandom_range(SC + 1, 12)));
            model_capture(seq[i], s);
            hold_pins(BLANK, 8'hFF, int'($urandom_range(1, 3)));
         end
         hold_pins(BLANK, 8'hFF, 3);
         n_vec++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL random%0d_valid: got %b want 1", r, frame_valid); end
         n_vec++; if (frame_bcd !== m_bcd) begin n_bad++; $display("[TB] FAIL random%0d_bcd: got %h want %h", r, frame_bcd, m_bcd); end
         n_vec++; if (frame_dp !== m_dp) begin n_bad++; $display("[TB] FAIL random%0d_dp: got %b want %b", r, frame_dp, m_dp); end
         n_vec++; if (frame_err !== m_err) begin n_bad++; $display("[TB] FAIL random%0d_err: got %b want %b", r, frame_err, m_err); end
         frame_ready = 1'b1;
         tick();
         n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL random%0d_accept: got %b want 0", r, frame_valid); end
         frame_ready = 1'b0;
      end
   endtask

   task automatic test_overrun();
      logic [4*ND-1:0] a_bcd;
      logic [ND-1:0]   a_dp, a_err;
      logic [7:0]      s;
      logic            want;
      frame_ready = 1'b0;
      hold_pins(BLANK, 8'hFF, 3);
      for (int k = 0; k < ND; k++) begin
         s = rand_seg();
         hold_pins(dig(k), s, 8);
         model_capture(k, s);
         hold_pins(BLANK, 8'hFF, 2);
      end
      a_bcd = m_bcd;
      a_dp  = m_dp;
      a_err = m_err;
      n_vec++; if (frame_valid !== 1'b1 || frame_bcd !== a_bcd) begin
         n_bad++;
         $display("[TB] FAIL overrun_first: got %b/%h want 1/%h", frame_valid, frame_bcd, a_bcd);
      end
      for (int k = 0; k < ND; k++) begin
         s = rand_seg();
         set_pins(dig(k), s);
         model_capture(k, s);
         for (int e = 1; e <= 8; e++) begin
            tick();
            want = (k == ND - 1) && (e == SC + 2);
            n_vec++; if (overrun !== want) begin
               n_bad++;
               $display("[TB] FAIL overrun_pulse_d%0d_e%0d: got %b want %b", k, e, overrun, want);
            end
            n_vec++; if (frame_valid !== 1'b1 || frame_bcd !== a_bcd || frame_dp !== a_dp || frame_err !== a_err) begin
               n_bad++;
               $display("[TB] FAIL overrun_held: got %b/%h/%b/%b want 1/%h/%b/%b", frame_valid, frame_bcd, frame_dp, frame_err, a_bcd, a_dp, a_err);
            end
         end
         hold_pins(BLANK, 8'hFF, 2);
      end
      frame_ready = 1'b1;
      tick();
      n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL overrun_accept: got %b want 0", frame_valid); end
      frame_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4*ND-1:0] a_bcd;
      logic [7:0]      s;
      frame_ready = 1'b0;
      hold_pins(BLANK, 8'hFF, 3);
      for (int k = 0; k < ND; k++) begin
         s = rand_seg();
         hold_pins(dig(k), s, 8);
         model_capture(k, s);
         hold_pins(BLANK, 8'hFF, 2);
      end
      a_bcd = m_bcd;
      for (int k = 0; k < ND - 1; k++) begin
         s = rand_seg();
         hold_pins(dig(k), s, 8);
         model_capture(k, s);
         hold_pins(BLANK, 8'hFF, 2);
      end
      s = rand_seg();
      set_pins(dig(ND - 1), s);
      model_capture(ND - 1, s);
      for (int e = 1; e <= SC + 3; e++) begin
         tick();
         n_vec++; if (overrun !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_overrun_e%0d: got %b want 0", e, overrun); end
         if (e <= SC + 1) begin
            n_vec++; if (frame_valid !== 1'b1 || frame_bcd !== a_bcd) begin
               n_bad++;
               $display("[TB] FAIL b2b_old_e%0d: got %b/%h want 1/%h", e, frame_valid, frame_bcd, a_bcd);
            end
         end else if (e == SC + 2) begin
            n_vec++; if (frame_valid !== 1'b1 || frame_bcd !== m_bcd || frame_dp !== m_dp || frame_err !== m_err) begin
               n_bad++;
               $display("[TB] FAIL b2b_new: got %b/%h/%b/%b want 1/%h/%b/%b", frame_valid, frame_bcd, frame_dp, frame_err, m_bcd, m_dp, m_err);
            end
         end else begin
            n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_drop: got %b want 0", frame_valid); end
         end
         if (e == SC + 1) frame_ready = 1'b1;
      end
      frame_ready = 1'b0;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] s;
      int         pulses;
      frame_ready = 1'b1;
      hold_pins(BLANK, 8'hFF, 3);
      for (int k = 0; k < 2; k++) begin
         s = rand_seg();
         hold_pins(dig(k), s, 8);
      end
      @(negedge clk);
      rst_n  = 1'b0;
      an_in  = BLANK;
      seg_in = 8'hFF;
      #1;
      n_vec++; if (frame_valid !== 1'b0 || overrun !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL midreset_flags: got %b/%b want 0/0", frame_valid, overrun);
      end
      n_vec++; if (frame_bcd !== '0 || frame_dp !== '0 || frame_err !== '0) begin
         n_bad++;
         $display("[TB] FAIL midreset_data: got %h/%b/%b want 0/0/0", frame_bcd, frame_dp, frame_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      hold_pins(BLANK, 8'hFF, 3);
      for (int k = 2; k < ND; k++) begin
         s = rand_seg();
         set_pins(dig(k), s);
         model_capture(k, s);
         repeat (10) begin
            tick();
            n_vec++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_stale_seen: got %b want 0", frame_valid); end
         end
      end
      pulses = 0;
      for (int k = 0; k < 2; k++) begin
         s = rand_seg();
         set_pins(dig(k), s);
         model_capture(k, s);
         repeat (10) begin
            tick();
            if (frame_valid === 1'b1) pulses++;
         end
      end
      n_vec++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL midreset_pulses: got %0d want 1", pulses); end
      n_vec++; if (frame_bcd !== m_bcd || frame_dp !== m_dp || frame_err !== m_err) begin
         n_bad++;
         $display("[TB] FAIL midreset_frame: got %h/%b/%b want %h/%b/%b", frame_bcd, frame_dp, frame_err, m_bcd, m_dp, m_err);
      end
   endtask

   initial begin
      glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      m_bcd = '0;
      m_dp  = '0;
      m_err = '0;
      $display("[TB] starting seg_scan_reader bench");
      test_reset();
      test_basic();
      test_decode();
      test_glitch();
      test_random();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Reader end of the multiplexed 7-segment display interface: samples an active-low digit-select bus and an active-low 8-bit segment bus, and recovers per-digit BCD codes and decimal points.
- Assembles one complete scan of all digits into a frame and hands it out on a valid/ready interface.
- Used for display loop-back self-check and for scraping front panels driven by external controllers.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- STABLE_CYCLES, 4, consecutive synchronized cycles a {an_in, seg_in} pair must hold before capture; legal range 2..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- an_in  input  NUM_DIGITS  digit select, active-low; bit k selects digit k; asynchronous to clk
- seg_in  input  8  segments, active-low; bit7=DP, bits6:0=g..a; asynchronous to clk
- frame_valid  output  1  frame available
- frame_ready  input  1  consumer accepts frame
- frame_bcd  output  4*NUM_DIGITS  digit k code in bits [4k+3:4k]
- frame_dp  output  NUM_DIGITS  1 = DP lit on digit k
- frame_err  output  NUM_DIGITS  1 = digit k pattern was not a legal glyph
- overrun  output  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset (async, rst_n=0): all outputs 0, synchronizers 0, stability counter 0, seen mask 0, FSM=COLLECT; everything restarts cleanly on release, including when reset is asserted mid-frame.
- Input path:
  - an_in and seg_in each pass through a 2-flop synchronizer; the result is the sync pair.
  - A saturating counter increments while the sync pair equals its previous value, and clears on any change.
- Capture rule: fires exactly once per stable episode, when the pair has been unchanged for STABLE_CYCLES cycles. For pins settling before edge 1, capture is at edge STABLE_CYCLES+1.
  - Capture requires an_in to have exactly one bit low. All-high (blanking) or multiple-low: no capture and no error.
- Decode of seg bits6:0 (hex pattern → code):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F (blank) → F, err=0.
  - Any other pattern → E, err=1.
  - DP = ~seg bit7.
- Slot storage: capture for digit k writes slot k (code, dp, err) and sets seen[k]. Recapture within a frame overwrites the slot; latest wins.
- FSM COLLECT: when seen is all ones, on that edge load output registers from the slots, set frame_valid=1, clear seen, go to HOLD. frame_valid is 1 on the edge after the last digit's capture.
- FSM HOLD: outputs stay frozen; collection into the slots continues.
  - frame_valid & frame_ready: frame_valid→0 next edge, go to COLLECT.
  - Next frame completes while not accepted: overrun=1 for one cycle, seen cleared, the new frame is discarded, outputs unchanged.
  - Handshake and frame completion on the same edge: load the new frame, frame_valid stays 1, stay in HOLD, no overrun.
- frame_valid never drops without a handshake except on reset. Outputs are stable while frame_valid=1 and frame_ready=0.
- No combinational path from inputs to outputs.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=4, frame_ready=1. Drive digits 0..3 with seg C0, F9, A4, B0, each held 10 cycles → frame_bcd=16'h3210, frame_dp=0, frame_err=0, frame_valid high at edge 6 after the digit-3 pattern settles.
- Digit 1 seg=10 (bit7=0), digit 2 seg=FF, digit 3 seg=8C, others 80 → bcd nibbles {E,F,9,8}, frame_dp=4'b0010, frame_err=4'b1000.
- Glitch: hold each pattern 3 cycles only; then an_in=4'b0011 and an_in=4'b1111, each held 20 cycles → no capture, frame_valid stays 0.
- frame_ready=0: complete two full scans → first frame held unchanged, overrun pulses exactly 1 cycle at second completion. Then raise frame_ready → valid drops one edge later.
- Hold frame_ready=1 so a handshake coincides with the next frame's completion → new data loaded, frame_valid continuous, overrun=0.
- Assert rst_n=0 for 1 cycle after 2 digits captured → all outputs 0 immediately. A full fresh scan afterwards yields a correct frame with no stale slot data.
